rom_wb_ctrl: RTL and testbench
==============================

# rom_wb_ctrl

Wishbone B3 slave controller that fronts the 32-word OR1K startup ROM and sequences its registered-address read port. It turns classic and incrementing-burst bus cycles from the instruction/data arbiter into ROM word addresses, generates acknowledge and error, and sustains one beat per clock during bursts. The ROM itself is unchanged; this block sits between the boot-ROM Wishbone slave port and the ROM.

## Interface
- `ADDR_W`, 5: ROM word-address width (depth = 2^ADDR_W words).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_adr_i` in 32: byte address; only bits [ADDR_W+1:2] are decoded.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: Wishbone cycle, strobe, write enable.
- `wb_sel_i` in 4: byte selects; ignored (full-word reads).
- `wb_cti_i` in 3: cycle type; 000 classic, 010 incrementing burst, 111 end of burst.
- `wb_bte_i` in 2: burst type; 00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap.
- `wb_ack_o` out 1: acknowledge.
- `wb_err_o` out 1: error, used for write attempts.
- `rom_addr_o` out ADDR_W: word address to ROM; the ROM registers it on `clk`.
- `rom_data_i` in 32: ROM data, valid the cycle after `rom_addr_o` is sampled.

## Operation
- States: IDLE, CLASSIC, BURST, ERR.
- IDLE: `rom_addr_o` = `wb_adr_i[ADDR_W+1:2]` combinationally. On `wb_cyc_i & wb_stb_i`:
  - `wb_we_i` = 1 -> ERR.
  - `wb_cti_i` = 010 -> BURST.
  - otherwise -> CLASSIC.
- CLASSIC: `wb_ack_o` = 1 for exactly one cycle, `wb_dat_o` = `rom_data_i`, then return to IDLE. The ack is forced low for at least one cycle before the next access.
- ERR: `wb_err_o` = 1 for one cycle, then IDLE. The ROM is not affected.
- BURST:
  - Internal `cur_addr` holds the word whose data is being presented.
  - While `wb_stb_i` stays high and `wb_cti_i` = 010:
    - ack every cycle.
    - `rom_addr_o` = `next_addr(cur_addr, wb_bte_i)`.
    - `cur_addr` advances on each acked beat.
  - `wb_stb_i` low mid-burst (master wait): no ack next cycle; `rom_addr_o` holds `cur_addr`; resume with no lost or duplicated beat.
  - Beat acked with `wb_cti_i` = 111: last beat; go to IDLE.
  - `wb_we_i` rising mid-burst: ERR.
- `next_addr` rules:
  - Linear: +1 modulo 2^ADDR_W (wraps 31 -> 0).
  - Wrap-4/8/16: increment only the low 2/3/4 bits; upper bits are fixed.
- `wb_cyc_i` low in any state returns to IDLE in the next cycle, with `wb_ack_o` and `wb_err_o` low. An in-flight beat is discarded.
- Addresses above ROM depth alias by truncation and are never errors.
- `wb_dat_o` = 0 whenever `wb_ack_o` = 0.

## Timing
- Reset (async assert, sync release to IDLE): `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0, `cur_addr` = 0. `rom_addr_o` follows `wb_adr_i[ADDR_W+1:2]` while in reset (IDLE decode).
- Classic read: request seen at cycle N; ack and data at N+1. Minimum 2 cycles per classic access.
- Burst: first ack at N+1, then one beat per cycle. A B-beat burst with no waits completes at N+B.
- Write: `wb_err_o` at N+1 for one cycle.
- `wb_ack_o` and `wb_err_o` are registered, never both high, and never high while `wb_cyc_i` was low in the previous cycle.
- Reset asserted mid-burst: outputs clear immediately (asynchronously); no ack after release until a new request.

## Structure
- Shared package `or1k_wb_pkg`:
  - CTI constants `CTI_CLASSIC`, `CTI_INC`, `CTI_EOB`.
  - BTE constants `BTE_LIN`, `BTE_WRAP4`, `BTE_WRAP8`, `BTE_WRAP16`.
  - State enum `rom_ctrl_state_t`.
- The `next_addr` wrap logic is one pure-combinational function in the package. No sub-module is needed.
- Top level integration instantiates `rom_wb_ctrl` driving the existing startup ROM.

## Test plan
- Classic read of `wb_adr_i` = 0x0C, ROM model per word index -> ack one cycle later with `wb_dat_o` = ROM[3] (0xA8A00520); ack low the following cycle.
- Linear 4-beat burst from 0x70 (word 28) -> beats ROM[28], ROM[29], ROM[30], ROM[31] on consecutive cycles. A continued 5th beat returns ROM[0].
- Wrap-4 burst from 0x08 (word 2), 4 beats, last beat with cti = 111 -> words 2, 3, 0, 1; IDLE afterwards.
- Burst with `wb_stb_i` low for 2 cycles after beat 2 -> no ack during the gap; beat 3 = next sequential word; no duplicate or skipped word.
- Write cycle to 0x00 -> `wb_err_o` high exactly one cycle, `wb_ack_o` never high. A subsequent read of word 0 returns 0x18000000.
- `rst_n` low during beat 3 of an 8-beat burst -> ack and data clear immediately. After release, a classic read of word 5 returns 0x04000014.

Source files
------------

// File: rtl/or1k_wb_pkg.sv
// Shared Wishbone definitions for the OR1K boot-ROM path: cycle/burst type
// codes, the ROM controller state encoding and the burst address stepper.
package or1k_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LIN    = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2,
    ST_ERR     = 2'd3
  } rom_ctrl_state_t;

  // Word address of the next burst beat; callers truncate to their own width,
  // which gives linear bursts their modulo-depth wrap.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] bte);
    logic [31:0] inc_s;
    inc_s = addr + 32'd1;
    case (bte)
      BTE_LIN:    next_addr = inc_s;
      BTE_WRAP4:  next_addr = {addr[31:2], inc_s[1:0]};
      BTE_WRAP8:  next_addr = {addr[31:3], inc_s[2:0]};
      BTE_WRAP16: next_addr = {addr[31:4], inc_s[3:0]};
      default:    next_addr = inc_s;
    endcase
  endfunction

endpackage

// File: rtl/rom_wb_ctrl.sv
// Wishbone B3 read-only slave in front of the registered-address startup ROM:
// classic and incrementing bursts at one beat per clock, errors on writes.
module rom_wb_ctrl
  import or1k_wb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       wb_adr_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i
);

  rom_ctrl_state_t   state_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic              ack_r;
  logic              err_r;

  logic [ADDR_W-1:0] adr_word_s;
  logic [31:0]       nxt_full_s;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [ADDR_W-1:0] rom_addr_s;
  logic [31:0]       dat_s;
  logic              adv_s;

  assign adr_word_s = wb_adr_i[ADDR_W+1:2];
  assign nxt_full_s = next_addr(32'(cur_addr_r), wb_bte_i);
  assign nxt_addr_s = nxt_full_s[ADDR_W-1:0];
  // A beat is consumed only when the master still strobes during our ack.
  assign adv_s      = ack_r & wb_stb_i & (wb_cti_i == CTI_INC);

  // ROM address: bus decode when idle, prefetch of the following beat in bursts.
  always_comb begin
    rom_addr_s = adr_word_s;
    if (state_r == ST_BURST) begin
      if (adv_s) begin
        rom_addr_s = nxt_addr_s;
      end else begin
        rom_addr_s = cur_addr_r;
      end
    end else begin
      rom_addr_s = adr_word_s;
    end
  end

  // Read data is gated to zero outside acknowledged cycles.
  always_comb begin
    dat_s = 32'd0;
    if (ack_r) begin
      dat_s = rom_data_i;
    end else begin
      dat_s = 32'd0;
    end
  end

  // Bus cycle sequencer with registered ack/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cur_addr_r <= {ADDR_W{1'b0}};
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
    end else if (!wb_cyc_i) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wb_stb_i) begin
            cur_addr_r <= adr_word_s;
            if (wb_we_i) begin
              state_r <= ST_ERR;
              ack_r   <= 1'b0;
              err_r   <= 1'b1;
            end else if (wb_cti_i == CTI_INC) begin
              state_r <= ST_BURST;
              ack_r   <= 1'b1;
              err_r   <= 1'b0;
            end else begin
              state_r <= ST_CLASSIC;
              ack_r   <= 1'b1;
              err_r   <= 1'b0;
            end
          end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
          end
        end
        ST_CLASSIC, ST_ERR: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
        ST_BURST: begin
          // A dropped strobe leaves cur_addr pointing at the unconsumed beat.
          if (wb_stb_i && wb_we_i) begin
            state_r <= ST_ERR;
            ack_r   <= 1'b0;
            err_r   <= 1'b1;
          end else if (!wb_stb_i) begin
            ack_r <= 1'b0;
          end else if (!ack_r) begin
            ack_r <= 1'b1;
          end else if (wb_cti_i == CTI_INC) begin
            cur_addr_r <= nxt_addr_s;
            ack_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o   = ack_r;
  assign wb_err_o   = err_r;
  assign wb_dat_o   = dat_s;
  assign rom_addr_o = rom_addr_s;

endmodule

// File: tb/tb_rom_wb_ctrl.sv
// Directed bench for rom_wb_ctrl: a registered-address ROM model, a Wishbone
// master, and a scoreboard of expected beat data derived from address arithmetic.
module tb_rom_wb_ctrl;
  import or1k_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] dat;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [2:0]  cti = CTI_CLASSIC;
  logic [1:0]  bte = BTE_LIN;
  logic        ack, err;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data = 32'd0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic        prev_cyc = 1'b0;

  rom_wb_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_o(dat),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack), .wb_err_o(err),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int i);
    case (i)
      0:       rom_val = 32'h1800_0000;
      3:       rom_val = 32'hA8A0_0520;
      5:       rom_val = 32'h0400_0014;
      default: rom_val = 32'h9C21_0000 + 32'(i);
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

  // Word index of beat i of a burst: wrapping bursts keep the bits above the wrap span.
  function automatic int burst_word(input int start, input int bt, input int i);
    int mask;
    mask = (bt == 0) ? 31 : ((2 << bt) - 1);
    return (start & ~mask) | ((start + i) & mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Scoreboard and protocol rules, evaluated once per cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack && stb && cyc) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", dat);
        end else begin
          check("beat_data", dat, exp_q.pop_front());
        end
      end
      vectors++;
      if ((ack && err) || (!ack && dat != 32'd0) || ((ack || err) && !prev_cyc)) begin
        miscompares++;
        $display("FAIL protocol: got ack=%b err=%b dat=%h prev_cyc=%b, expected exclusive ack/err, zero idle data, no response after idle",
                 ack, err, dat, prev_cyc);
      end
    end
    prev_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic classic_read(input logic [31:0] a, input logic [31:0] lit, input bit hold);
    int lat;
    exp_q.push_back(rom_val(int'(a[6:2])));
    step();
    adr = a; cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = CTI_CLASSIC;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 8);
    check("classic_latency", 32'(lat), 32'd2);
    check("classic_data", dat, lit);
    if (!hold) begin
      step();
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("classic_ack_drop", {31'd0, ack}, 32'd0);
    end
  endtask

  task automatic write_err();
    int lat;
    step();
    adr = 32'd0; cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = CTI_CLASSIC;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!err && lat < 8);
    check("err_latency", 32'(lat), 32'd2);
    check("write_no_ack", {31'd0, ack}, 32'd0);
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("err_one_cycle", {30'd0, err, ack}, 32'd0);
  endtask

  task automatic burst(input int start, input logic [1:0] bt, input int nbeats,
                       input int gap_after, input int gap_len, input int rst_at);
    int done, cycles, gap_left, gap_idx;
    done = 0; cycles = 0; gap_left = gap_len; gap_idx = 0;
    for (int i = 0; i < nbeats; i++) exp_q.push_back(rom_val(burst_word(start, int'(bt), i)));
    step();
    adr = 32'(start) << 2; cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = bt;
    cti = (nbeats == 1) ? CTI_EOB : CTI_INC;
    while (done < nbeats && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (ack && stb) done++;
      if (!stb && gap_idx >= 2) check("gap_no_ack", {31'd0, ack}, 32'd0);
      if (done == nbeats) break;
      step();
      if (gap_after != 0 && done == gap_after && gap_left > 0) begin
        stb = 1'b0; gap_left--; gap_idx++;
      end else begin
        stb = 1'b1;
      end
      cti = (done == nbeats - 1) ? CTI_EOB : CTI_INC;
      if (rst_at != 0 && done == rst_at - 1) begin
        #1;
        check("beat_before_reset", {31'd0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_clears_ack", {31'd0, ack}, 32'd0);
        check("reset_clears_dat", dat, 32'd0);
        cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("post_reset_quiet", {30'd0, err, ack}, 32'd0);
        end
        return;
      end
    end
    check("burst_beats", 32'(done), 32'(nbeats));
    if (gap_len == 0) check("burst_cycles", 32'(cycles), 32'(nbeats + 1));
    step();
    cyc = 1'b0; stb = 1'b0; cti = CTI_CLASSIC;
    adr = 32'hFFFF_FF8C;
    @(negedge clk);
    check("burst_end_ack", {31'd0, ack}, 32'd0);
    check("burst_idle_decode", {27'd0, rom_addr}, 32'd3);
    check("burst_all_beats_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    check("model_lin_wrap", 32'(burst_word(28, 0, 4)), 32'd0);
    check("model_wrap4", 32'(burst_word(2, 1, 2)), 32'd0);
    check("model_wrap8", 32'(burst_word(13, 2, 3)), 32'd8);
    check("model_wrap16", 32'(burst_word(29, 3, 3)), 32'd16);

    adr = 32'h0000_007C;
    #2;
    check("reset_rom_addr", {27'd0, rom_addr}, 32'd31);
    check("reset_outputs", {30'd0, ack, err}, 32'd0);
    check("reset_dat", dat, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    classic_read(32'h0000_000C, 32'hA8A0_0520, 1'b0);
    write_err();
    classic_read(32'h0000_0000, 32'h1800_0000, 1'b0);
    classic_read(32'h0000_0014, 32'h0400_0014, 1'b1);
    classic_read(32'h0000_008C, 32'hA8A0_0520, 1'b0);

    burst(28, BTE_LIN, 5, 0, 0, 0);
    burst(2, BTE_WRAP4, 4, 0, 0, 0);
    burst(10, BTE_LIN, 5, 2, 2, 0);
    burst(29, BTE_WRAP16, 5, 0, 0, 0);
    burst(13, BTE_WRAP8, 8, 0, 0, 3);

    classic_read(32'h0000_0014, 32'h0400_0014, 1'b0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
